// File: rtl/freq_stream_packer_if.sv
// freq_stream_packer_if
// AXI4-Stream output bus of the frequency stream packer.
//   m_axis_tdata  : 32-bit output beat
//   m_axis_tvalid : beat valid
//   m_axis_tready : downstream ready
//   m_axis_tlast  : last beat of a sample
// master modport: the packer (drives data/valid/last, reads ready).
// slave modport : the downstream consumer.
interface freq_stream_packer_if;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/freq_stream_packer.sv
// freq_stream_packer
// Buffers per-tone samples from the frequency selector in a small FIFO and
// serialises each one into three 32-bit AXI4-Stream beats. Every accepted
// sample carries a wrapping sequence number; samples arriving while the FIFO
// is full are dropped and counted.
// Ports:
//   dev_clk, dev_rstn : clock, asynchronous active-low reset
//   valid_in          : single-cycle sample strobe (no backpressure)
//   data_in[79:0]     : sample payload
//   index_in[6:0]     : tone index
//   axis              : AXI4-Stream master (tdata/tvalid/tready/tlast)
//   overflow          : sticky drop flag
//   drop_count[15:0]  : saturating drop counter
//   clr_overflow      : pulse clearing overflow and drop_count
module freq_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int SEQ_WIDTH  = 9
) (
  input  logic                        dev_clk,
  input  logic                        dev_rstn,
  input  logic                        valid_in,
  input  logic [79:0]                 data_in,
  input  logic [6:0]                  index_in,
  freq_stream_packer_if.master        axis,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  input  logic                        clr_overflow
);

  localparam int EW = SEQ_WIDTH + 7 + 80;  // {seq, index, data} = 96 bits
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;              // occupancy spans 0..FIFO_DEPTH

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_W0   = 2'd1;
  localparam logic [1:0] ST_W1   = 2'd2;
  localparam logic [1:0] ST_W2   = 2'd3;

  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [SEQ_WIDTH-1:0] seq_q;
  logic [EW-1:0]        out_q;
  logic [1:0]           state_q, state_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic full, empty, push, drop, pop;

  // full is judged on the registered count, so a pop in the same cycle
  // cannot rescue an incoming sample.
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = valid_in && !full;
  assign drop  = valid_in && full;

  // Output FSM: a pop loads the output register; W2's handshake chains
  // straight into the next sample so there is no bubble between samples.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_W0;
        end
      end
      ST_W0: if (axis.m_axis_tready) state_d = ST_W1;
      ST_W1: if (axis.m_axis_tready) state_d = ST_W2;
      ST_W2: begin
        if (axis.m_axis_tready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_W0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  // A drop coinciding with a clear wins: the flag stays set and the count
  // restarts at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow)              drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  // Sample storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge dev_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {seq_q, index_in, data_in};
  end

  always_ff @(posedge dev_clk or negedge dev_rstn) begin
    if (!dev_rstn) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      seq_q      <= '0;
      out_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        seq_q    <= seq_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_q    <= fifo_mem[rd_ptr_q];
      end
    end
  end

  // Beat select is a pure function of registered state, so tdata/tlast stay
  // stable while the FSM waits for tready.
  always_comb begin
    axis.m_axis_tdata = 32'd0;
    case (state_q)
      ST_W0:   axis.m_axis_tdata = out_q[95:64];
      ST_W1:   axis.m_axis_tdata = out_q[63:32];
      ST_W2:   axis.m_axis_tdata = out_q[31:0];
      default: axis.m_axis_tdata = 32'd0;
    endcase
  end

  assign axis.m_axis_tvalid = (state_q != ST_IDLE);
  assign axis.m_axis_tlast  = (state_q == ST_W2);
  assign overflow           = overflow_q;
  assign drop_count         = drop_cnt_q;

endmodule
